mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 op  in  6  opcode field of the instruction register (IR[31:26]).
REQ-004 mem_ready  in  1  memory handshake; high = current memory access completes this cycle.
REQ-005 pc_write  out  1  unconditional PC update.
REQ-006 branch  out  1  PC update qualified by ALU zero (beq).
REQ-007 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 mem_read / mem_write  out  1 each  memory strobes.
REQ-009 ir_write  out  1  instruction register load.
REQ-010 reg_write, reg_dst, mem_to_reg  out  1 each  register-file write controls.
REQ-011 alu_src_a  out  1 and alu_src_b  out  2  ALU operand selects; alu_src_b: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-012 pc_src  out  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-013 Alu_op  out  2  to the ALU control decoder: 00 = add, 01 = sub, 10 = decode funct.
REQ-014 illegal_op  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-015 Moore FSM; all outputs are decoded from the registered state only; no input-to-output combinational path.
REQ-016 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, ADDI_EX, ADDI_WB, JUMP.
REQ-017 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, Alu_op=00, pc_src=00; ir_write=1 and pc_write=1 only while mem_ready=1.
REQ-018 FETCH holds while mem_ready=0; goes to DECODE on mem_ready=1.
REQ-019 DECODE: alu_src_a=0, alu_src_b=11, Alu_op=00 (branch target precompute).
REQ-020 DECODE next state by op: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> RTYPE_EX; 000100 -> BEQ_EX; 001000 -> ADDI_EX; 000010 -> JUMP; any other -> FETCH with illegal_op=1 for that one cycle.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10, Alu_op=00; goes to MEMRD if op=lw, else MEMWR.
REQ-022 MEMRD: mem_read=1, iord=1; holds until mem_ready=1, then goes to MEMWB.
REQ-023 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; goes to FETCH.
REQ-024 MEMWR: mem_write=1, iord=1; holds until mem_ready=1, then goes to FETCH.
REQ-025 RTYPE_EX: alu_src_a=1, alu_src_b=00, Alu_op=10 -> RTYPE_WB. RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-026 BEQ_EX: alu_src_a=1, alu_src_b=00, Alu_op=01, branch=1, pc_src=01 -> FETCH.
REQ-027 ADDI_EX: alu_src_a=1, alu_src_b=10, Alu_op=00 -> ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-028 JUMP: pc_write=1, pc_src=10 -> FETCH.
REQ-029 Any output not listed for a state is 0.
REQ-030 Latency when mem_ready is always 1: lw 5 cycles, sw/R-type/addi 4 cycles, beq/j 3 cycles, illegal 2 cycles.
REQ-031 An unreachable or corrupt state encoding goes to FETCH on the next edge.

Reset
REQ-032 reset=1 forces the state to FETCH on the next edge and overrides every transition, including mid-wait in MEMRD or MEMWR.
REQ-033 While reset=1, all outputs are 0, including FETCH strobes and illegal_op.

Structure
REQ-034 A shared package (mips_pkg) holds the state enum, the opcode constants, and the Alu_op, alu_src_b and pc_src encodings.
REQ-035 The block consists of a state register plus next-state logic and output decode; one optional sub-module, mips_mc_ctrl_decode (state -> outputs), is used. It does not instantiate the ALU control decoder.

Verification
REQ-036 reset=1 for 2 cycles, then released with mem_ready=1 -> FETCH with mem_read=1, ir_write=1, pc_write=1 in the first cycle after release.
REQ-037 op=100011, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 in cycle 5; back in FETCH in cycle 6.
REQ-038 op=000000 -> Alu_op=10 in RTYPE_EX; reg_dst=1 and reg_write=1 in the next cycle.
REQ-039 op=101011 with mem_ready held low for 3 cycles in MEMWR -> mem_write=1 for 4 cycles; FETCH follows the mem_ready=1 cycle.
REQ-040 op=111111 -> illegal_op pulses for exactly 1 cycle in DECODE; FETCH follows.
REQ-041 reset asserted while in MEMRD with mem_ready=0 -> next cycle in FETCH with all outputs 0 while reset=1.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS control unit: the FSM state
// encoding, the opcodes the controller understands, the encodings of the
// Alu_op / alu_src_b / pc_src selects, and the bundle of control signals that
// the state decoder produces.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control bundle decoded purely from the state. pc_write and ir_write here
  // are the "intent" of the state; the top qualifies the FETCH ones with
  // mem_ready.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // True for every opcode that has its own execution path out of DECODE.
  function automatic logic is_legal_op(input logic [5:0] opcode);
    case (opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: is_legal_op = 1'b1;
      default:                                       is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl_decode
// Pure state -> control-signal decoder for the multicycle MIPS controller.
// Ports:
//   i_state : current FSM state
//   o_ctrl  : control bundle for that state (unlisted signals are 0)
// -----------------------------------------------------------------------------
module mips_mc_ctrl_decode
  import mips_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  // Each state only raises the signals it needs; everything else stays 0,
  // including for corrupt encodings.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_RTYPE_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BEQ_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.branch    = 1'b1;
        o_ctrl.pc_src    = PCSRC_ALUOUT;
      end
      S_ADDI_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_src   = PCSRC_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl
// Multicycle MIPS main controller: state register, next-state logic and
// output qualification around the state decoder.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   op                  : IR[31:26]
//   mem_ready           : memory access completes this cycle
//   pc_write, branch    : PC update (unconditional / beq-qualified)
//   iord                : memory address select (0 PC, 1 ALUOut)
//   mem_read, mem_write : memory strobes
//   ir_write            : instruction register load
//   reg_write, reg_dst, mem_to_reg : register file write controls
//   alu_src_a, alu_src_b: ALU operand selects
//   pc_src              : PC source select
//   Alu_op              : to the ALU control decoder
//   illegal_op          : one-cycle pulse on an unsupported opcode
// -----------------------------------------------------------------------------
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] Alu_op,
  output logic       illegal_op
);

  state_t r_state;
  state_t w_next_state;
  ctrl_t  w_ctrl;
  logic   w_in_fetch;
  logic   w_in_decode;

  assign w_in_fetch  = (r_state == S_FETCH);
  assign w_in_decode = (r_state == S_DECODE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Memory-facing states wait on mem_ready; MEMADR picks read vs write from
  // the opcode still held in IR. Corrupt encodings recover to FETCH.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_RTYPE_EX;
          OP_BEQ:       w_next_state = S_BEQ_EX;
          OP_ADDI:      w_next_state = S_ADDI_EX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWR:    w_next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: w_next_state = S_RTYPE_WB;
      S_RTYPE_WB: w_next_state = S_FETCH;
      S_BEQ_EX:   w_next_state = S_FETCH;
      S_ADDI_EX:  w_next_state = S_ADDI_WB;
      S_ADDI_WB:  w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;
    endcase
  end

  mips_mc_ctrl_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Outputs are silenced while reset is held. The FETCH PC/IR loads only fire
  // on the cycle the instruction word actually arrives, and illegal_op flags
  // an unknown opcode during the single DECODE cycle.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    Alu_op     = 2'b00;
    illegal_op = 1'b0;
    if (!reset) begin
      pc_write   = w_ctrl.pc_write & (~w_in_fetch | mem_ready);
      branch     = w_ctrl.branch;
      iord       = w_ctrl.iord;
      mem_read   = w_ctrl.mem_read;
      mem_write  = w_ctrl.mem_write;
      ir_write   = w_ctrl.ir_write & mem_ready;
      reg_write  = w_ctrl.reg_write;
      reg_dst    = w_ctrl.reg_dst;
      mem_to_reg = w_ctrl.mem_to_reg;
      alu_src_a  = w_ctrl.alu_src_a;
      alu_src_b  = w_ctrl.alu_src_b;
      pc_src     = w_ctrl.pc_src;
      Alu_op     = w_ctrl.alu_op;
      illegal_op = w_in_decode & ~is_legal_op(op);
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_ctrl
// Scoreboard bench for the multicycle MIPS controller. The stimulus process
// tracks each instruction as a sequence of steps (fetch, decode, then an
// opcode-specific tail), pushes the expected output word for every cycle, and
// a monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_mips_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src, Alu_op;
  logic       illegal_op;

  mips_mc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .Alu_op     (Alu_op),
    .illegal_op (illegal_op)
  );

  // Clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    A_FETCH, A_DECODE, A_MEMADR, A_MEMRD, A_MEMWB, A_MEMWR,
    A_REX, A_RWB, A_BEX, A_AEX, A_AWB, A_JMP
  } action_t;

  typedef enum int { C_LW, C_SW, C_R, C_BEQ, C_ADDI, C_J, C_ILL } class_t;

  typedef struct {
    logic [16:0] v;
    int          cyc;
    action_t     a;
  } exp_t;

  exp_t   expQ[$];
  int     checks = 0;
  int     errors = 0;
  int     cycle  = 0;

  // Reference model position: 0 = fetch, 1 = decode, 2 = in instruction tail.
  int     phase  = 0;
  int     pos    = 0;
  class_t cls    = C_ILL;

  function automatic class_t classify(input logic [5:0] o);
    case (o)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return C_R;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int tailLen(input class_t c);
    case (c)
      C_LW:    return 3;
      C_SW:    return 2;
      C_R:     return 2;
      C_BEQ:   return 1;
      C_ADDI:  return 2;
      C_J:     return 1;
      default: return 0;
    endcase
  endfunction

  function automatic action_t tailStep(input class_t c, input int p);
    case (c)
      C_LW:    return (p == 0) ? A_MEMADR : ((p == 1) ? A_MEMRD : A_MEMWB);
      C_SW:    return (p == 0) ? A_MEMADR : A_MEMWR;
      C_R:     return (p == 0) ? A_REX : A_RWB;
      C_BEQ:   return A_BEX;
      C_ADDI:  return (p == 0) ? A_AEX : A_AWB;
      default: return A_JMP;
    endcase
  endfunction

  function automatic action_t currentAction();
    if (phase == 0) return A_FETCH;
    if (phase == 1) return A_DECODE;
    return tailStep(cls, pos);
  endfunction

  // Expected output word, packed in the same order as dutVec below.
  function automatic logic [16:0] expOut(input action_t a, input logic mr,
                                         input logic [5:0] o, input logic rst);
    logic       pcw, br, ad, mrd, mwr, irw, rw, rd, m2r, sa, ill;
    logic [1:0] sb, ps, ao;
    {pcw, br, ad, mrd, mwr, irw, rw, rd, m2r, sa, ill} = '0;
    sb = 2'b00;
    ps = 2'b00;
    ao = 2'b00;
    case (a)
      A_FETCH:  begin mrd = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
      A_DECODE: begin sb = 2'b11; ill = (classify(o) == C_ILL); end
      A_MEMADR: begin sa = 1'b1; sb = 2'b10; end
      A_MEMRD:  begin mrd = 1'b1; ad = 1'b1; end
      A_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      A_MEMWR:  begin mwr = 1'b1; ad = 1'b1; end
      A_REX:    begin sa = 1'b1; ao = 2'b10; end
      A_RWB:    begin rw = 1'b1; rd = 1'b1; end
      A_BEX:    begin sa = 1'b1; ao = 2'b01; br = 1'b1; ps = 2'b01; end
      A_AEX:    begin sa = 1'b1; sb = 2'b10; end
      A_AWB:    begin rw = 1'b1; end
      A_JMP:    begin pcw = 1'b1; ps = 2'b10; end
      default:  begin end
    endcase
    if (rst) return 17'd0;
    return {pcw, br, ad, mrd, mwr, irw, rw, rd, m2r, sa, sb, ps, ao, ill};
  endfunction

  logic [16:0] dutVec;
  assign dutVec = {pc_write, branch, iord, mem_read, mem_write, ir_write,
                   reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                   pc_src, Alu_op, illegal_op};

  // Drive one cycle of inputs, queue the expected outputs for it, then step
  // the reference model to where the next clock edge will take it.
  task automatic applyStimulus(input logic r, input logic [5:0] o, input logic mr);
    exp_t    e;
    action_t a;
    @(posedge clk);
    #1;
    reset     = r;
    op        = o;
    mem_ready = mr;
    cycle++;
    a     = currentAction();
    e.v   = expOut(a, mr, o, r);
    e.cyc = cycle;
    e.a   = a;
    expQ.push_back(e);
    if (r) begin
      phase = 0;
    end else if (phase == 0) begin
      if (mr) phase = 1;
    end else if (phase == 1) begin
      cls = classify(o);
      if (tailLen(cls) == 0) phase = 0;
      else begin
        phase = 2;
        pos   = 0;
      end
    end else begin
      if (!((a == A_MEMRD || a == A_MEMWR) && !mr)) begin
        pos++;
        if (pos == tailLen(cls)) phase = 0;
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (dutVec !== e.v) begin
      errors++;
      $display("[TB] FAIL outputs cycle=%0d step=%s got=%b expected=%b",
               e.cyc, e.a.name(), dutVec, e.v);
    end
  endtask

  // One full instruction from FETCH back to FETCH, with mem_ready held low for
  // the first waitCycles cycles spent in a memory-wait step.
  task automatic runInstr(input logic [5:0] o, input int waitCycles);
    int      waited;
    logic    mr;
    action_t a;
    waited = 0;
    applyStimulus(1'b0, o, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (phase == 0) break;
      a  = currentAction();
      mr = 1'b1;
      if ((a == A_MEMRD || a == A_MEMWR) && waited < waitCycles) begin
        mr = 1'b0;
        waited++;
      end
      applyStimulus(1'b0, o, mr);
    end
  endtask

  // Monitor: compares whatever the stimulus side has queued for this cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  logic [5:0] legalOps [6];
  logic [5:0] curOp;
  logic       rr;
  logic       mr;

  initial begin
    legalOps[0] = 6'b100011;
    legalOps[1] = 6'b101011;
    legalOps[2] = 6'b000000;
    legalOps[3] = 6'b000100;
    legalOps[4] = 6'b001000;
    legalOps[5] = 6'b000010;
    reset     = 1'b1;
    op        = 6'b000000;
    mem_ready = 1'b0;

    // Reset for two cycles, then straight into a lw with memory always ready.
    applyStimulus(1'b1, 6'b100011, 1'b1);
    applyStimulus(1'b1, 6'b100011, 1'b1);
    runInstr(6'b100011, 0);
    runInstr(6'b000000, 0);
    runInstr(6'b101011, 3);
    runInstr(6'b111111, 0);
    runInstr(6'b000100, 0);
    runInstr(6'b001000, 0);
    runInstr(6'b000010, 0);
    runInstr(6'b100011, 2);

    // Reset while stalled in the lw memory read.
    applyStimulus(1'b0, 6'b100011, 1'b1);
    applyStimulus(1'b0, 6'b100011, 1'b1);
    applyStimulus(1'b0, 6'b100011, 1'b1);
    applyStimulus(1'b0, 6'b100011, 1'b0);
    applyStimulus(1'b1, 6'b100011, 1'b0);
    applyStimulus(1'b1, 6'b100011, 1'b0);
    applyStimulus(1'b0, 6'b100011, 1'b1);

    // Random traffic: opcode changes only at instruction boundaries.
    curOp = 6'b000000;
    for (int i = 0; i < 3000; i++) begin
      if (phase == 0) begin
        if ($urandom_range(0, 9) < 8) curOp = legalOps[$urandom_range(0, 5)];
        else                          curOp = 6'($urandom_range(0, 63));
      end
      rr = ($urandom_range(0, 99) == 0);
      mr = ($urandom_range(0, 3) != 0);
      applyStimulus(rr, curOp, mr);
    end

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
